// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : branch_predictor
// Desc   : Direct-mapped BTB with 2-bit saturating counters, EX-stage
//          misprediction detection and branch/mispredict counters.
// Rev    : 1.0 - initial release
// ============================================================================
module branch_predictor #(
    parameter int IDX_W = 4,
    parameter int CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [31:0]      i_if_pc,
    output logic             o_pred_taken,
    output logic [31:0]      o_pred_pc,
    input  logic             i_ex_vld,
    input  logic             i_ex_br,
    input  logic             i_ex_jmp,
    input  logic [31:0]      i_ex_pc,
    input  logic             i_ex_taken,
    input  logic [31:0]      i_ex_target,
    input  logic             i_ex_pred_taken,
    input  logic [31:0]      i_ex_pred_pc,
    output logic             o_mispred,
    output logic [31:0]      o_redirect_pc,
    output logic [CNT_W-1:0] o_br_cnt,
    output logic [CNT_W-1:0] o_mis_cnt
);

    localparam int c_entries = 1 << IDX_W;
    localparam int c_tag_w   = 30 - IDX_W;

    logic [c_entries-1:0] r_valid;
    logic [c_tag_w-1:0]   r_tag    [c_entries];
    logic [31:0]          r_target [c_entries];
    logic [1:0]           r_ctr    [c_entries];
    logic [CNT_W-1:0]     r_br_cnt;
    logic [CNT_W-1:0]     r_mis_cnt;

    logic [IDX_W-1:0]     w_if_idx;
    logic [c_tag_w-1:0]   w_if_tag;
    logic                 w_if_hit;
    logic                 w_pred_taken;

    logic [IDX_W-1:0]     w_ex_idx;
    logic [c_tag_w-1:0]   w_ex_tag;
    logic                 w_ex_hit;
    logic                 w_ctl;
    logic                 w_actual;
    logic                 w_mispred;
    logic [1:0]           w_cur_ctr;
    logic [1:0]           w_new_ctr;
    logic                 w_tgt_we;
    logic                 w_unused;

    // Fetch-side lookup: reads the registered table only, so a same-cycle
    // update is never bypassed onto the prediction.
    assign w_if_idx     = i_if_pc[IDX_W+1:2];
    assign w_if_tag     = i_if_pc[31:IDX_W+2];
    assign w_if_hit     = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
    assign w_pred_taken = w_if_hit && r_ctr[w_if_idx][1];

    assign o_pred_taken = w_pred_taken;
    assign o_pred_pc    = w_pred_taken ? r_target[w_if_idx] : (i_if_pc + 32'd4);

    // EX-side resolution
    assign w_ex_idx  = i_ex_pc[IDX_W+1:2];
    assign w_ex_tag  = i_ex_pc[31:IDX_W+2];
    assign w_ex_hit  = r_valid[w_ex_idx] && (r_tag[w_ex_idx] == w_ex_tag);
    assign w_cur_ctr = r_ctr[w_ex_idx];
    assign w_ctl     = i_ex_vld && (i_ex_br || i_ex_jmp);
    assign w_actual  = i_ex_jmp || i_ex_taken;
    assign w_mispred = w_ctl && ((w_actual != i_ex_pred_taken) ||
                                 (w_actual && (i_ex_target != i_ex_pred_pc)));

    assign o_mispred     = w_mispred;
    assign o_redirect_pc = w_actual ? i_ex_target : (i_ex_pc + 32'd4);

    always_comb begin
        w_new_ctr = w_cur_ctr;
        w_tgt_we  = 1'b0;
        if (!w_ex_hit) begin
            w_new_ctr = w_actual ? 2'b10 : 2'b01;
            w_tgt_we  = 1'b1;
        end else if (w_actual) begin
            w_tgt_we = 1'b1;
            if (w_cur_ctr != 2'b11)
                w_new_ctr = w_cur_ctr + 2'b01;
        end else if (w_cur_ctr != 2'b00) begin
            w_new_ctr = w_cur_ctr - 2'b01;
        end
        // Jumps are unconditional, so they always land strongly taken
        if (i_ex_jmp)
            w_new_ctr = 2'b11;
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            for (int i = 0; i < c_entries; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_ctr[i]    <= 2'b01;
            end
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_ctl) begin
                r_valid[w_ex_idx] <= 1'b1;
                r_tag[w_ex_idx]   <= w_ex_tag;
                r_ctr[w_ex_idx]   <= w_new_ctr;
                if (w_tgt_we)
                    r_target[w_ex_idx] <= i_ex_target;
            end
            r_br_cnt  <= r_br_cnt  + CNT_W'(w_ctl);
            r_mis_cnt <= r_mis_cnt + CNT_W'(w_mispred);
        end
    end

    assign o_br_cnt  = r_br_cnt;
    assign o_mis_cnt = r_mis_cnt;

    // Byte-offset bits of word-aligned PCs carry no information here
    assign w_unused = ^{i_if_pc[1:0], i_ex_pc[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module : tb_branch_predictor
// Desc   : Directed self-checking bench for branch_predictor.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    logic        i_clk;
    logic        i_reset;
    logic [31:0] i_if_pc;
    logic        o_pred_taken;
    logic [31:0] o_pred_pc;
    logic        i_ex_vld;
    logic        i_ex_br;
    logic        i_ex_jmp;
    logic [31:0] i_ex_pc;
    logic        i_ex_taken;
    logic [31:0] i_ex_target;
    logic        i_ex_pred_taken;
    logic [31:0] i_ex_pred_pc;
    logic        o_mispred;
    logic [31:0] o_redirect_pc;
    logic [31:0] o_br_cnt;
    logic [31:0] o_mis_cnt;

    int checks = 0;
    int errors = 0;

    branch_predictor #(.IDX_W(4), .CNT_W(32)) dut (
        .i_clk          (i_clk),
        .i_reset        (i_reset),
        .i_if_pc        (i_if_pc),
        .o_pred_taken   (o_pred_taken),
        .o_pred_pc      (o_pred_pc),
        .i_ex_vld       (i_ex_vld),
        .i_ex_br        (i_ex_br),
        .i_ex_jmp       (i_ex_jmp),
        .i_ex_pc        (i_ex_pc),
        .i_ex_taken     (i_ex_taken),
        .i_ex_target    (i_ex_target),
        .i_ex_pred_taken(i_ex_pred_taken),
        .i_ex_pred_pc   (i_ex_pred_pc),
        .o_mispred      (o_mispred),
        .o_redirect_pc  (o_redirect_pc),
        .o_br_cnt       (o_br_cnt),
        .o_mis_cnt      (o_mis_cnt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic set_ex(input logic vld, input logic br, input logic jmp,
                          input logic [31:0] pc, input logic taken,
                          input logic [31:0] target, input logic ptaken,
                          input logic [31:0] ppc);
        i_ex_vld = vld; i_ex_br = br; i_ex_jmp = jmp; i_ex_pc = pc;
        i_ex_taken = taken; i_ex_target = target;
        i_ex_pred_taken = ptaken; i_ex_pred_pc = ppc;
    endtask

    task automatic clear_ex();
        set_ex(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic test_reset();
        i_reset = 1'b0;
        i_if_pc = 32'h0;
        clear_ex();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_reset = 1'b1;
        i_if_pc = 32'h40;
        #1;
        checks++; if (o_pred_taken !== 1'b0) begin errors++; $display("FAIL reset_pred_taken: got %b expected 0", o_pred_taken); end
        checks++; if (o_pred_pc !== 32'h44) begin errors++; $display("FAIL reset_pred_pc: got %h expected 00000044", o_pred_pc); end
        checks++; if (o_br_cnt !== 32'd0) begin errors++; $display("FAIL reset_br_cnt: got %0d expected 0", o_br_cnt); end
        checks++; if (o_mis_cnt !== 32'd0) begin errors++; $display("FAIL reset_mis_cnt: got %0d expected 0", o_mis_cnt); end
    endtask

    task automatic test_nonctl();
        @(negedge i_clk);
        set_ex(1'b1, 1'b0, 1'b0, 32'h40, 1'b1, 32'h99, 1'b1, 32'h99);
        #1;
        checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL nonctl_mispred: got %b expected 0", o_mispred); end
        @(posedge i_clk); #1;
        set_ex(1'b0, 1'b1, 1'b0, 32'h40, 1'b1, 32'h99, 1'b0, 32'h44);
        #1;
        checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL invalid_mispred: got %b expected 0", o_mispred); end
        @(posedge i_clk); #1;
        clear_ex();
        i_if_pc = 32'h40;
        #1;
        checks++; if (o_br_cnt !== 32'd0) begin errors++; $display("FAIL nonctl_br_cnt: got %0d expected 0", o_br_cnt); end
        checks++; if (o_pred_pc !== 32'h44) begin errors++; $display("FAIL nonctl_no_write: got %h expected 00000044", o_pred_pc); end
    endtask

    task automatic test_branch_training();
        logic        pt;
        logic [31:0] pp;
        @(negedge i_clk);
        i_if_pc = 32'h40; #1;
        pt = o_pred_taken; pp = o_pred_pc;
        set_ex(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h20, pt, pp); #1;
        checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL train1_mispred: got %b expected 1", o_mispred); end
        checks++; if (o_redirect_pc !== 32'h20) begin errors++; $display("FAIL train1_redirect: got %h expected 00000020", o_redirect_pc); end
        @(posedge i_clk); #1;
        clear_ex();
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_if_pc = 32'h40; #1;
            pt = o_pred_taken; pp = o_pred_pc;
            checks++; if (pp !== 32'h20) begin errors++; $display("FAIL train%0d_pred_pc: got %h expected 00000020", k + 2, pp); end
            set_ex(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h20, pt, pp); #1;
            checks++; if (o_mispred !== 1'b0) begin errors++; $display("FAIL train%0d_mispred: got %b expected 0", k + 2, o_mispred); end
            @(posedge i_clk); #1;
            clear_ex();
        end
        @(negedge i_clk);
        i_if_pc = 32'h40; #1;
        checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL trained_taken: got %b expected 1", o_pred_taken); end
        checks++; if (o_pred_pc !== 32'h20) begin errors++; $display("FAIL trained_pc: got %h expected 00000020", o_pred_pc); end
        checks++; if (o_br_cnt !== 32'd3) begin errors++; $display("FAIL trained_br_cnt: got %0d expected 3", o_br_cnt); end
        checks++; if (o_mis_cnt !== 32'd1) begin errors++; $display("FAIL trained_mis_cnt: got %0d expected 1", o_mis_cnt); end
    endtask

    task automatic test_hysteresis();
        logic        pt;
        logic [31:0] pp;
        logic        exp_pt [2];
        logic [31:0] exp_pp [2];
        exp_pt[0] = 1'b1; exp_pp[0] = 32'h20;
        exp_pt[1] = 1'b0; exp_pp[1] = 32'h44;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            i_if_pc = 32'h40; #1;
            pt = o_pred_taken; pp = o_pred_pc;
            set_ex(1'b1, 1'b1, 1'b0, 32'h40, 1'b0, 32'h20, pt, pp); #1;
            checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL nt%0d_mispred: got %b expected 1", k + 1, o_mispred); end
            checks++; if (o_redirect_pc !== 32'h44) begin errors++; $display("FAIL nt%0d_redirect: got %h expected 00000044", k + 1, o_redirect_pc); end
            @(posedge i_clk); #1;
            clear_ex();
            #1;
            checks++; if (o_pred_taken !== exp_pt[k]) begin errors++; $display("FAIL nt%0d_after_taken: got %b expected %b", k + 1, o_pred_taken, exp_pt[k]); end
            checks++; if (o_pred_pc !== exp_pp[k]) begin errors++; $display("FAIL nt%0d_after_pc: got %h expected %h", k + 1, o_pred_pc, exp_pp[k]); end
        end
        checks++; if (o_mis_cnt !== 32'd3) begin errors++; $display("FAIL nt_mis_cnt: got %0d expected 3", o_mis_cnt); end
    endtask

    task automatic test_aliasing();
        logic        pt;
        logic [31:0] pp;
        // counter at 01 -> one taken resolution brings it to 10
        @(negedge i_clk);
        i_if_pc = 32'h40; #1;
        pt = o_pred_taken; pp = o_pred_pc;
        set_ex(1'b1, 1'b1, 1'b0, 32'h40, 1'b1, 32'h20, pt, pp);
        @(posedge i_clk); #1;
        clear_ex(); #1;
        checks++; if (o_pred_taken !== 1'b1) begin errors++; $display("FAIL alias_retrain: got %b expected 1", o_pred_taken); end
        @(negedge i_clk);
        i_if_pc = 32'h80; #1;
        checks++; if (o_pred_pc !== 32'h84) begin errors++; $display("FAIL alias_jmp_pred: got %h expected 00000084", o_pred_pc); end
        pt = o_pred_taken; pp = o_pred_pc;
        set_ex(1'b1, 1'b0, 1'b1, 32'h80, 1'b0, 32'h100, pt, pp); #1;
        checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL alias_jmp_mispred: got %b expected 1", o_mispred); end
        checks++; if (o_redirect_pc !== 32'h100) begin errors++; $display("FAIL alias_jmp_redirect: got %h expected 00000100", o_redirect_pc); end
        @(posedge i_clk); #1;
        clear_ex();
        i_if_pc = 32'h40; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h44) begin errors++; $display("FAIL alias_old_evicted: got %b/%h expected 0/00000044", o_pred_taken, o_pred_pc); end
        i_if_pc = 32'h80; #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h100) begin errors++; $display("FAIL alias_new_entry: got %b/%h expected 1/00000100", o_pred_taken, o_pred_pc); end
        checks++; if (o_br_cnt !== 32'd7 || o_mis_cnt !== 32'd5) begin errors++; $display("FAIL alias_counts: got %0d/%0d expected 7/5", o_br_cnt, o_mis_cnt); end
    endtask

    task automatic test_same_index();
        // seed the entry at 0x10 with target 0x200
        @(negedge i_clk);
        i_if_pc = 32'h10; #1;
        set_ex(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h200, o_pred_taken, o_pred_pc);
        @(posedge i_clk); #1;
        clear_ex();
        @(negedge i_clk);
        i_if_pc = 32'h10; #1;
        checks++; if (o_pred_taken !== 1'b1 || o_pred_pc !== 32'h200) begin errors++; $display("FAIL jalr_seed: got %b/%h expected 1/00000200", o_pred_taken, o_pred_pc); end
        set_ex(1'b1, 1'b0, 1'b1, 32'h10, 1'b0, 32'h300, 1'b1, 32'h200); #1;
        checks++; if (o_mispred !== 1'b1) begin errors++; $display("FAIL jalr_mispred: got %b expected 1", o_mispred); end
        checks++; if (o_redirect_pc !== 32'h300) begin errors++; $display("FAIL jalr_redirect: got %h expected 00000300", o_redirect_pc); end
        checks++; if (o_pred_pc !== 32'h200) begin errors++; $display("FAIL same_cycle_read: got %h expected 00000200", o_pred_pc); end
        @(posedge i_clk); #1;
        clear_ex(); #1;
        checks++; if (o_pred_pc !== 32'h300) begin errors++; $display("FAIL next_cycle_read: got %h expected 00000300", o_pred_pc); end
        checks++; if (o_br_cnt !== 32'd9 || o_mis_cnt !== 32'd7) begin errors++; $display("FAIL jalr_counts: got %0d/%0d expected 9/7", o_br_cnt, o_mis_cnt); end
    endtask

    task automatic test_mid_reset();
        @(negedge i_clk);
        set_ex(1'b1, 1'b1, 1'b0, 32'h60, 1'b1, 32'h500, 1'b0, 32'h64);
        #2;
        i_reset = 1'b0;
        i_if_pc = 32'h10;
        #1;
        checks++; if (o_br_cnt !== 32'd0 || o_mis_cnt !== 32'd0) begin errors++; $display("FAIL midrst_counts: got %0d/%0d expected 0/0", o_br_cnt, o_mis_cnt); end
        checks++; if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h14) begin errors++; $display("FAIL midrst_table: got %b/%h expected 0/00000014", o_pred_taken, o_pred_pc); end
        @(posedge i_clk); #1;
        clear_ex();
        @(negedge i_clk);
        i_reset = 1'b1;
        i_if_pc = 32'h60; #1;
        checks++; if (o_pred_taken !== 1'b0 || o_pred_pc !== 32'h64) begin errors++; $display("FAIL midrst_no_write: got %b/%h expected 0/00000064", o_pred_taken, o_pred_pc); end
        checks++; if (o_br_cnt !== 32'd0) begin errors++; $display("FAIL midrst_br_after: got %0d expected 0", o_br_cnt); end
    endtask

    initial begin
        test_reset();
        test_nonctl();
        test_branch_training();
        test_hysteresis();
        test_aliasing();
        test_same_index();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 SHALL have parameter IDX_W, default 4, meaning table index width (2**IDX_W entries).
REQ-002 SHALL have parameter CNT_W, default 32, meaning width of each performance counter.
REQ-003 SHALL have port i_clk  input  1  meaning single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_reset  input  1  meaning asynchronous, active-low reset; 0 asserts.
REQ-005 SHALL have port i_if_pc  input  32  meaning PC of the instruction being fetched.
REQ-006 SHALL have port o_pred_taken  output  1  meaning prediction for i_if_pc: 1 = taken.
REQ-007 SHALL have port o_pred_pc  output  32  meaning predicted next PC for i_if_pc.
REQ-008 SHALL have port i_ex_vld  input  1  meaning the EX-stage instruction is valid and not flushed.
REQ-009 SHALL have port i_ex_br  input  1  meaning the EX instruction is a conditional branch.
REQ-010 SHALL have port i_ex_jmp  input  1  meaning the EX instruction is JAL/JALR.
REQ-011 SHALL have port i_ex_pc  input  32  meaning PC of the EX instruction.
REQ-012 SHALL have port i_ex_taken  input  1  meaning resolved branch outcome (ignored for jumps, treated as 1).
REQ-013 SHALL have port i_ex_target  input  32  meaning resolved target address.
REQ-014 SHALL have port i_ex_pred_taken  input  1  meaning o_pred_taken carried down the pipeline with the instruction.
REQ-015 SHALL have port i_ex_pred_pc  input  32  meaning o_pred_pc carried down the pipeline with the instruction.
REQ-016 SHALL have port o_mispred  output  1  meaning EX instruction mispredicted; IF/ID and ID/EX flush required.
REQ-017 SHALL have port o_redirect_pc  output  32  meaning correct next PC when o_mispred=1.
REQ-018 SHALL have port o_br_cnt  output  CNT_W  meaning count of resolved control-transfer instructions.
REQ-019 SHALL have port o_mis_cnt  output  CNT_W  meaning count of mispredictions.

Function
REQ-020 SHALL hold per entry: valid bit, tag = pc[31:IDX_W+2], 32-bit target, 2-bit saturating counter; index = pc[IDX_W+1:2].
REQ-021 SHALL produce the prediction combinationally, in the same cycle as i_if_pc: hit = valid and tag match; o_pred_taken = hit and counter[1]; o_pred_pc = stored target if o_pred_taken, else i_if_pc+4 (mod 2**32).
REQ-022 SHALL define ctl = i_ex_vld and (i_ex_br or i_ex_jmp), and actual = i_ex_jmp or i_ex_taken.
REQ-023 SHALL assert o_mispred combinationally when ctl=1 and (actual != i_ex_pred_taken, or actual=1 and i_ex_target != i_ex_pred_pc).
REQ-024 SHALL drive o_mispred = 0 whenever ctl=0, including when i_ex_pred_taken=1 on a non-control instruction.
REQ-025 SHALL drive o_redirect_pc = i_ex_target when actual=1, else i_ex_pc+4.
REQ-026 SHALL update the entry at the i_ex_pc index on the rising edge when ctl=1, as follows.
REQ-027 On a tag miss or invalid entry, the update SHALL write valid=1 and the new tag, with target = i_ex_target; the counter SHALL be 2'b10 if actual=1, else 2'b01.
REQ-028 On a tag hit, the update SHALL increment the counter if actual=1 (saturating at 2'b11), else decrement it (saturating at 2'b00); the target SHALL be rewritten only when actual=1.
REQ-029 SHALL force counter = 2'b11 on every jump update.
REQ-030 When a fetch read and an EX write hit the same index in one cycle, the read SHALL return the pre-update contents (no bypass); the new value SHALL be visible the next cycle.
REQ-031 SHALL increment o_br_cnt by 1 per cycle with ctl=1, and o_mis_cnt by 1 per cycle with o_mispred=1; both SHALL wrap modulo 2**CNT_W.
REQ-032 SHALL have a one-cycle latency from update to prediction; there is no handshake and the block never stalls.

Reset
REQ-033 While i_reset=0, asynchronously, all valid bits SHALL be 0, all counters 2'b01, targets 0, and o_br_cnt = o_mis_cnt = 0.
REQ-034 Immediately after reset, o_pred_taken SHALL be 0 and o_pred_pc = i_if_pc+4.
REQ-035 An update in flight when reset asserts SHALL be discarded; the table SHALL show no partial write.

Verification
REQ-036 Reset: release reset, i_if_pc=0x40 -> o_pred_taken=0, o_pred_pc=0x44, counters 0.
REQ-037 Branch training: branch at 0x40 to 0x20 resolved taken three times, with the predictions fed back -> first resolution gives o_mispred=1 and o_redirect_pc=0x20; second gives o_mispred=0; i_if_pc=0x40 then predicts taken to 0x20; o_br_cnt=3, o_mis_cnt=1.
REQ-038 Saturation and hysteresis: a counter at 2'b11 followed by one not-taken -> still predicts taken; a second not-taken -> predicts not-taken; the not-taken mispredict gives o_redirect_pc=0x44.
REQ-039 Aliasing: 0x40 trained taken, then a jump at 0x80 (same index with IDX_W=4) to 0x100 -> entry replaced; 0x40 then predicts not-taken; 0x80 predicts 0x100.
REQ-040 Target change and same-index read: JALR at 0x10 with predicted target 0x200 resolves to 0x300 -> o_mispred=1; a fetch of 0x10 in the same cycle returns 0x200, and in the next cycle returns 0x300.
REQ-041 Mid-operation reset: assert i_reset=0 on a cycle with ctl=1 -> table and counters are cleared immediately; no entry is written.
